// File: rtl/operand_fetch_if.sv
// Handshake and data bundle between the instruction source, the operand_fetch
// stage and the combinational ALU.
//
// Signals:
//   in_valid / in_ready / in_instr    : instruction issue handshake
//   out_valid / out_ready             : operand handshake toward the ALU
//   out_a / out_b / out_instr         : registered ALU operands and instruction
//   alu_s / alu_ze                    : ALU result and zero flag for current out_*
//   zflag / retire_count              : architectural status of retired work
//
// Modports:
//   slave  : the operand_fetch stage
//   master : the environment (instruction source plus ALU)
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] out_instr;
  logic [31:0] alu_s;
  logic        alu_ze;
  logic        zflag;
  logic [31:0] retire_count;

  modport slave (
    input  in_valid,
    input  in_instr,
    input  out_ready,
    input  alu_s,
    input  alu_ze,
    output in_ready,
    output out_valid,
    output out_a,
    output out_b,
    output out_instr,
    output zflag,
    output retire_count
  );

  modport master (
    output in_valid,
    output in_instr,
    output out_ready,
    output alu_s,
    output alu_ze,
    input  in_ready,
    input  out_valid,
    input  out_a,
    input  out_b,
    input  out_instr,
    input  zflag,
    input  retire_count
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch / writeback stage in front of a combinational ALU.
//
// Holds the 32x32 register file (R0 hard-wired to zero), decodes the incoming
// instruction into source operands and presents registered a/b/instruction to
// the ALU. When the ALU side consumes the operands the result is written back
// to rd, the zero flag is latched and the retire counter advances. A result
// retiring in the same cycle as a dependent accept is forwarded directly.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : operand_fetch_if.slave (issue handshake, ALU operands, ALU result,
//         zflag, retire_count)
//
// Instruction fields: [4:0] opcode, [9:5] rd, [14:10] rs1, [19:15] rs2,
// [20] imm, [31:21] imm11 (sign-extended when imm=1).
module operand_fetch (
  input logic           clk,
  input logic           rst,
  operand_fetch_if.slave bus
);

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } state_e;

  state_e state_q, state_d;

  logic [31:0] rf_q [32];

  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        zflag_q, zflag_d;

  logic        accept;
  logic        retire;
  logic        out_valid;

  // Decoded fields of the incoming instruction.
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        in_imm;
  logic [31:0] in_imm_sext;

  // Destination of the instruction currently on out_*.
  logic [4:0]  wb_rd;
  logic        wb_en;

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign in_rs1      = bus.in_instr[14:10];
  assign in_rs2      = bus.in_instr[19:15];
  assign in_imm      = bus.in_instr[20];
  assign in_imm_sext = {{21{bus.in_instr[31]}}, bus.in_instr[31:21]};

  assign wb_rd = instr_q[9:5];

  assign out_valid = (state_q == StFull);
  assign retire    = out_valid & bus.out_ready;
  assign accept    = bus.in_valid & bus.in_ready;
  assign wb_en     = retire & (wb_rd != 5'd0);

  // Register reads with same-cycle forwarding of the retiring result.
  always_comb begin
    rs1_val = rf_q[in_rs1];
    rs2_val = rf_q[in_rs2];
    if (in_rs1 == 5'd0) begin
      rs1_val = 32'd0;
    end else if (wb_en && (wb_rd == in_rs1)) begin
      rs1_val = bus.alu_s;
    end
    if (in_rs2 == 5'd0) begin
      rs2_val = 32'd0;
    end else if (wb_en && (wb_rd == in_rs2)) begin
      rs2_val = bus.alu_s;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    instr_d = instr_q;
    count_d = count_q;
    zflag_d = zflag_q;

    if (accept) begin
      a_d     = rs1_val;
      b_d     = in_imm ? in_imm_sext : rs2_val;
      instr_d = bus.in_instr;
    end

    if (retire) begin
      count_d = count_q + 32'd1;
      zflag_d = bus.alu_ze;
    end

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
        end
      end
      StFull: begin
        // Stall holds, retire+accept refills, bare retire drains.
        if (retire && !accept) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      instr_q <= 32'd0;
      count_q <= 32'd0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      instr_q <= instr_d;
      count_q <= count_d;
      zflag_q <= zflag_d;
    end
  end

  // R0 is never written, so it stays zero from reset onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if (wb_en) begin
      rf_q[wb_rd] <= bus.alu_s;
    end
  end

  assign bus.in_ready     = !out_valid | bus.out_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_a        = a_q;
  assign bus.out_b        = b_q;
  assign bus.out_instr    = instr_q;
  assign bus.zflag        = zflag_q;
  assign bus.retire_count = count_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vectors with literal expectations plus a
// behavioural model compared against the DUT on every falling edge.
module tb_operand_fetch;

  logic clk;
  logic rst;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic imm,
                                     input logic [10:0] imm11, input logic [4:0] op);
    return {imm11, imm, rs2, rs1, rd, op};
  endfunction

  // Behavioural model: architectural registers plus the single output slot.
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_a, m_b, m_instr, m_cnt;
  logic        m_z;
  logic        m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_valid = 1'b0;
      m_a = 32'd0; m_b = 32'd0; m_instr = 32'd0; m_cnt = 32'd0; m_z = 1'b0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      logic ret, acc;
      logic [31:0] ins;
      ret = m_valid && bus.out_ready;
      acc = bus.in_valid && (!m_valid || bus.out_ready);
      ins = bus.in_instr;
      // Writeback first, so an accepting reader observes the retiring result.
      if (ret) begin
        if (m_instr[9:5] != 5'd0) m_rf[m_instr[9:5]] = bus.alu_s;
        m_z = bus.alu_ze;
        m_cnt = m_cnt + 1;
      end
      if (acc) begin
        m_a = m_rf[ins[14:10]];
        m_b = ins[20] ? {{21{ins[31]}}, ins[31:21]} : m_rf[ins[19:15]];
        m_instr = ins;
        m_valid = 1'b1;
      end else if (ret) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok && !rst) begin
      check("model_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      check("model_in_ready", {31'd0, bus.in_ready}, {31'd0, !m_valid || bus.out_ready});
      check("model_zflag", {31'd0, bus.zflag}, {31'd0, m_z});
      check("model_retire_count", bus.retire_count, m_cnt);
      if (m_valid) begin
        check("model_out_a", bus.out_a, m_a);
        check("model_out_b", bus.out_b, m_b);
        check("model_out_instr", bus.out_instr, m_instr);
      end
    end
  end

  // Applies one cycle of inputs; returns just after the following rising edge.
  task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic [31:0] s, input logic ze);
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.alu_s     = s;
    bus.alu_ze    = ze;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stall_instr;

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_a", bus.out_a, 32'd0);
    check("rst_out_b", bus.out_b, 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_zflag", {31'd0, bus.zflag}, 32'd0);
    check("rst_count", bus.retire_count, 32'd0);

    // A: rd=1 rs1=5 rs2=6 reg operands, both zero after reset.
    drive(1'b1, mk(5'd1, 5'd5, 5'd6, 1'b0, 11'd0, 5'd3), 1'b0, 32'd0, 1'b0);
    check("idle_out_a", bus.out_a, 32'd0);
    check("idle_out_b", bus.out_b, 32'd0);
    check("idle_out_valid", {31'd0, bus.out_valid}, 32'd1);
    // B: imm11=0x7FF; retires A writing R1=0x11.
    drive(1'b1, mk(5'd0, 5'd0, 5'd0, 1'b1, 11'h7FF, 5'd1), 1'b1, 32'h11, 1'b0);
    check("imm_neg_out_b", bus.out_b, 32'hFFFF_FFFF);
    check("count_1", bus.retire_count, 32'd1);
    // C: rd=2 imm11=0x3FF; retires B (rd=0, result discarded).
    drive(1'b1, mk(5'd2, 5'd0, 5'd0, 1'b1, 11'h3FF, 5'd2), 1'b1, 32'h77, 1'b0);
    check("imm_pos_out_b", bus.out_b, 32'h0000_03FF);
    // D: rd=3 rs1=1; retires C writing R2=0x22.
    drive(1'b1, mk(5'd3, 5'd1, 5'd0, 1'b0, 11'd0, 5'd4), 1'b1, 32'h22, 1'b0);
    check("rf_read_r1", bus.out_a, 32'h11);
    // Retire D writing R3, then an idle cycle.
    drive(1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(1'b0, 32'd0, 1'b1, 32'h0, 1'b0);
    // G: rd=7 rs1=3 rs2=2 from the register file.
    drive(1'b1, mk(5'd7, 5'd3, 5'd2, 1'b0, 11'd0, 5'd5), 1'b1, 32'h0, 1'b0);
    check("wb_read_r3", bus.out_a, 32'hDEAD_BEEF);
    check("wb_read_r2", bus.out_b, 32'h22);
    // H: rd=4 rs1=rs2=7 bypassing G's result 42.
    drive(1'b1, mk(5'd4, 5'd7, 5'd7, 1'b0, 11'd0, 5'd6), 1'b1, 32'd42, 1'b0);
    check("bypass_a", bus.out_a, 32'd42);
    check("bypass_b", bus.out_b, 32'd42);
    // I: rd=0 rs1=4 bypassing H's result 5.
    drive(1'b1, mk(5'd0, 5'd4, 5'd0, 1'b0, 11'd0, 5'd7), 1'b1, 32'd5, 1'b0);
    check("bypass_r4", bus.out_a, 32'd5);
    // J: rd=5 rs1=rs2=0; I retires with rd=0 so nothing is forwarded.
    drive(1'b1, mk(5'd5, 5'd0, 5'd0, 1'b0, 11'd0, 5'd8), 1'b1, 32'd9, 1'b0);
    check("r0_no_bypass_a", bus.out_a, 32'd0);
    check("r0_no_bypass_b", bus.out_b, 32'd0);
    check("count_7", bus.retire_count, 32'd7);
    stall_instr = bus.out_instr;

    // Stall three cycles with a new instruction waiting.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(5'd6, 5'd5, 5'd1, 1'b0, 11'd0, 5'd9), 1'b0, 32'h55, 1'b1);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_instr", bus.out_instr, stall_instr);
      check("stall_count", bus.retire_count, 32'd7);
      check("stall_zflag", {31'd0, bus.zflag}, 32'd0);
    end
    // Release: J retires (R5=0x55, ze=1), waiting instruction accepted with bypass.
    drive(1'b1, mk(5'd6, 5'd5, 5'd1, 1'b0, 11'd0, 5'd9), 1'b1, 32'h55, 1'b1);
    check("release_out_a", bus.out_a, 32'h55);
    check("release_out_b", bus.out_b, 32'h11);
    check("release_zflag", {31'd0, bus.zflag}, 32'd1);
    check("release_count", bus.retire_count, 32'd8);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

    // Reset while FULL with a simultaneous retire and accept request.
    rst = 1'b1;
    drive(1'b1, mk(5'd1, 5'd1, 5'd1, 1'b0, 11'd0, 5'd1), 1'b1, 32'h99, 1'b1);
    rst = 1'b0;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_count", bus.retire_count, 32'd0);
    check("midrst_zflag", {31'd0, bus.zflag}, 32'd0);
    drive(1'b1, mk(5'd1, 5'd6, 5'd5, 1'b0, 11'd0, 5'd2), 1'b0, 32'd0, 1'b0);
    check("midrst_r6", bus.out_a, 32'd0);
    check("midrst_r5", bus.out_b, 32'd0);

    // Mixed traffic on a few registers to exercise hazards against the model.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 4) == 0), 11'($urandom), 5'($urandom)),
            1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch / writeback stage sitting directly upstream of the combinational ALU. It holds the 32×32 architectural register file, decodes source/destination fields from each incoming instruction and presents registered `a`, `b`, `instruction` to the ALU. One cycle later it writes the ALU result `s` back into the destination register and latches the ALU zero flag `ze`. It uses a valid/ready handshake on both sides with full-throughput bypassing.

## Interface
- No parameters. The data width is fixed at 32, with 32 registers.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: an instruction is offered on `in_instr`.
- `in_ready` out 1: the stage accepts `in_instr` this cycle.
- `in_instr` in 32: instruction word.
- `out_valid` out 1: `out_a`, `out_b`, `out_instr` are valid for the ALU.
- `out_ready` in 1: downstream consumes the current operands this cycle.
- `out_a` out 32: ALU operand a.
- `out_b` out 32: ALU operand b.
- `out_instr` out 32: instruction word forwarded to the ALU (opcode in [4:0]).
- `alu_s` in 32: ALU result for the current `out_*` (combinational from the ALU).
- `alu_ze` in 1: ALU zero flag for the current `out_*`.
- `zflag` out 1: `alu_ze` of the last retired instruction.
- `retire_count` out 32: number of retired instructions.

## Operation
- Field decode of `in_instr`:
  - [4:0] opcode, passed through untouched.
  - [9:5] rd.
  - [14:10] rs1.
  - [19:15] rs2.
  - [20] imm.
  - [31:21] imm11.
- Operand a = R[rs1].
- Operand b = R[rs2] when imm=0; otherwise imm11 sign-extended to 32 bits (bit 31 of `in_instr` replicated into [31:11]).
- R0 always reads 0. Writes to R0 are discarded, and no bypass is taken from rd=0.
- Accept: `in_valid & in_ready`. On accept, the computed a/b and `in_instr` are loaded into the output registers and `out_valid` is set to 1.
- `in_ready` = `!out_valid | out_ready`, combinational. This allows back-to-back issue with no bubbles.
- Retire: `out_valid & out_ready`. On retire:
  - R[out_instr[9:5]] ← `alu_s` (unless rd=0).
  - `zflag` ← `alu_ze`.
  - `retire_count` increments by 1, wrapping 0xFFFFFFFF→0.
- Retire without a simultaneous accept clears `out_valid`.
- Bypass: when a retire and an accept happen in the same cycle and the retiring rd (≠0) equals the accepting rs1 (or rs2 with imm=0), the operand is `alu_s` rather than the stale register value. Both sources may bypass at once.
- Stall: while `out_valid & !out_ready`, the output registers hold steady, and the register file, `zflag` and counter do not change.
- States: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on stall, or on retire+accept.
  - FULL→EMPTY on retire without accept.

## Timing
- Reset, effective at the next rising edge:
  - `out_valid`=0, `out_a`=`out_b`=`out_instr`=0.
  - `zflag`=0, `retire_count`=0.
  - All R[1..31]=0.
  - `in_ready`=1 in the first cycle after reset.
- Reset mid-operation discards the in-flight instruction with no writeback, and takes priority over a simultaneous accept or retire.
- Latency: an instruction accepted at edge N is presented on `out_*` from edge N onward. Its writeback occurs at the edge where `out_ready`=1.
- A dependent instruction issued in the very next cycle sees the result through the bypass. Any later instruction reads it from the register file.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- `alu_s` and `alu_ze` are sampled only at a retire edge and are otherwise ignored.

## Test plan
- Reset, then idle:
  - All outputs are 0 and `in_ready`=1.
  - Issue rs1=5, rs2=6, imm=0 → `out_a`=0, `out_b`=0.
- Immediate sign-extension:
  - imm=1, imm11=0x7FF → `out_b`=0xFFFFFFFF.
  - imm11=0x3FF → `out_b`=0x000003FF.
- Writeback then read:
  - Issue rd=3 with `alu_s`=0xDEADBEEF and `out_ready`=1, then an idle cycle, then issue rs1=3 → `out_a`=0xDEADBEEF.
- Back-to-back bypass:
  - Issue rd=7 (`alu_s`=42), then immediately rs1=7, rs2=7 → `out_a`=`out_b`=42.
  - Also rd=0 with `alu_s`=9, then rs1=0 → `out_a`=0.
- Stall:
  - Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and `out_*` unchanged.
  - `retire_count` and register file unchanged.
  - Release → one retire, and the new instruction is accepted in the same cycle.
- Zero flag, counter and reset mid-flight:
  - Retire with `alu_ze`=1 → `zflag`=1; `retire_count` advances per retire.
  - Assert `rst` while FULL → `out_valid`=0, no writeback, `retire_count`=0.
